// File: rtl/joy_serial_rx.sv
// ---------------------------------------------------------------------------
// joy_serial_rx
//
// Serial receiver for a pair of daisy-chained joystick shift registers.
// A free-running divider produces the shift clock; every rising edge of
// that clock advances a 26-slot frame counter and samples one data bit into
// a shadow frame. A completed frame only reaches the button outputs when it
// matches the frame before it, so a one-frame glitch never shows up.
//
// Parameters
//   HALF_DIV    clk cycles per half-period of joy_clk (2..255)
//
// Ports
//   clk         single clock for all logic
//   rst_n       synchronous active-low reset
//   joy_data    serial data from the external shift register
//   joy_clk     registered shift clock to the external shift register
//   joy_load    registered active-low parallel-load strobe (low in slot 0)
//   joystick1   filtered player-1 buttons, active-low
//   joystick2   filtered player-2 buttons, active-low
//   frame_done  one-clk pulse when a frame has been committed
// ---------------------------------------------------------------------------
module joy_serial_rx #(
  parameter int unsigned HALF_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [11:0] joystick1,
  output logic [11:0] joystick2,
  output logic        frame_done
);

  localparam int unsigned      DIV_W     = $clog2(2 * HALF_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * HALF_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(HALF_DIV);
  localparam logic [4:0]       LAST_SLOT = 5'd25;
  localparam logic [11:0]      ALL_OFF   = 12'hFFF;

  logic [DIV_W-1:0] div_q,  div_d;
  logic             joy_clk_q, joy_clk_d;
  logic             joy_load_q, joy_load_d;
  logic [4:0]       slot_q, slot_d;
  logic [11:0]      sh1_q, sh1_d;
  logic [11:0]      sh2_q, sh2_d;
  logic [11:0]      pv1_q, pv1_d;
  logic [11:0]      pv2_q, pv2_d;
  logic [11:0]      joy1_q, joy1_d;
  logic [11:0]      joy2_q, joy2_d;
  logic             frame_done_q, frame_done_d;
  logic             rise;
  logic             commit;

  // Shift-clock divider. The rise is the cycle in which the registered
  // joy_clk is about to go 0 -> 1, so every rise-qualified update lands on
  // the same edge as the visible clock transition.
  always_comb begin
    div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    joy_clk_d = (div_d >= DIV_HALF);
    rise      = joy_clk_d & ~joy_clk_q;
  end

  // Slot counter; any value at or beyond the last slot wraps to 0, which
  // also recovers from the unreachable codes 26..31.
  always_comb begin
    slot_d = slot_q;
    if (rise) begin
      slot_d = (slot_q >= LAST_SLOT) ? '0 : slot_q + 5'd1;
    end
    joy_load_d = (slot_d != '0);
  end

  // Shadow frame capture: the bit sampled on a rise belongs to the slot
  // the counter held before advancing. Slots 0 and 1 carry no button data.
  // NOTE: every signal driven here gets its default before the case, so a
  // slot with no assignment holds its value instead of inferring a latch.
  always_comb begin
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    if (rise) begin
      case (slot_q)
        5'd2:    sh1_d[8]  = joy_data;
        5'd3:    sh1_d[6]  = joy_data;
        5'd4:    sh1_d[5]  = joy_data;
        5'd5:    sh1_d[4]  = joy_data;
        5'd6:    sh1_d[3]  = joy_data;
        5'd7:    sh1_d[2]  = joy_data;
        5'd8:    sh1_d[1]  = joy_data;
        5'd9:    sh1_d[0]  = joy_data;
        5'd10:   sh2_d[8]  = joy_data;
        5'd11:   sh2_d[6]  = joy_data;
        5'd12:   sh2_d[5]  = joy_data;
        5'd13:   sh2_d[4]  = joy_data;
        5'd14:   sh2_d[3]  = joy_data;
        5'd15:   sh2_d[2]  = joy_data;
        5'd16:   sh2_d[1]  = joy_data;
        5'd17:   sh2_d[0]  = joy_data;
        5'd18:   sh2_d[10] = joy_data;
        5'd19:   sh2_d[11] = joy_data;
        5'd20:   sh2_d[9]  = joy_data;
        5'd21:   sh2_d[7]  = joy_data;
        5'd22:   sh1_d[10] = joy_data;
        5'd23:   sh1_d[11] = joy_data;
        5'd24:   sh1_d[9]  = joy_data;
        5'd25:   sh1_d[7]  = joy_data;
        default: ;
      endcase
    end
  end

  // Frame commit on the slot-25 rise. The comparison uses the next-state
  // shadow so the bit captured on this very rise is part of the frame.
  // Two matching frames in a row are required before the outputs move.
  always_comb begin
    commit       = rise && (slot_q == LAST_SLOT);
    frame_done_d = commit;
    pv1_d        = pv1_q;
    pv2_d        = pv2_q;
    joy1_d       = joy1_q;
    joy2_d       = joy2_q;
    if (commit) begin
      pv1_d = sh1_d;
      pv2_d = sh2_d;
      if ({sh1_d, sh2_d} == {pv1_q, pv2_q}) begin
        joy1_d = sh1_d;
        joy2_d = sh2_d;
      end
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q        <= '0;
      joy_clk_q    <= 1'b0;
      joy_load_q   <= 1'b0;
      slot_q       <= '0;
      sh1_q        <= ALL_OFF;
      sh2_q        <= ALL_OFF;
      pv1_q        <= ALL_OFF;
      pv2_q        <= ALL_OFF;
      joy1_q       <= ALL_OFF;
      joy2_q       <= ALL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
      slot_q       <= slot_d;
      sh1_q        <= sh1_d;
      sh2_q        <= sh2_d;
      pv1_q        <= pv1_d;
      pv2_q        <= pv2_d;
      joy1_q       <= joy1_d;
      joy2_q       <= joy2_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign joy_clk    = joy_clk_q;
  assign joy_load   = joy_load_q;
  assign joystick1  = joy1_q;
  assign joystick2  = joy2_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/joy_serial_rx.md
JOY_SERIAL_RX -- requirements
Module: joy_serial_rx

Interface
REQ-001 The block SHALL have parameter HALF_DIV, default 16, giving clk cycles per half-period of joy_clk (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port joy_data, input, 1, serial data from the external joystick shift register.
REQ-005 The block SHALL have port joy_clk, output, 1, registered shift clock to the external shift register.
REQ-006 The block SHALL have port joy_load, output, 1, registered active-low parallel-load strobe.
REQ-007 The block SHALL have port joystick1, output, 12, filtered player-1 buttons, active-low.
REQ-008 The block SHALL have port joystick2, output, 12, filtered player-2 buttons, active-low.
REQ-009 The block SHALL have port frame_done, output, 1, one-clk pulse at the end of each 26-slot frame.

Function
REQ-010 A divider counter div_cnt SHALL run 0..2*HALF_DIV-1 and wrap, with joy_clk registered high while div_cnt >= HALF_DIV and low otherwise.
REQ-011 A "rise" event SHALL be the single clk cycle in which joy_clk transitions 0->1, once per 2*HALF_DIV clk cycles.
REQ-012 A 5-bit slot counter SHALL advance on each rise: 0,1,...,25, then back to 0. Values 26..31 are unreachable, and if ever present SHALL be forced to 0 on the next rise.
REQ-013 joy_load SHALL be 0 throughout the interval in which slot == 0, and 1 otherwise, updated in the same cycle as the slot counter.
REQ-014 On a rise with slot == k, joy_data SHALL be stored into a shadow frame register before the slot advances.
  - Slots 0 and 1: discarded.
  - Slots 2..9 -> sh1[8],[6],[5],[4],[3],[2],[1],[0].
  - Slots 10..17 -> sh2[8],[6],[5],[4],[3],[2],[1],[0].
  - Slots 18..21 -> sh2[10],[11],[9],[7].
  - Slots 22..25 -> sh1[10],[11],[9],[7].
REQ-015 Each frame SHALL be committed on the rise with slot == 25, using the shadow frame including the slot-25 bit.
  - frame_done pulses high for exactly one clk cycle, in the cycle after that rise.
  - The completed frame {sh1,sh2} is compared with the previous completed frame {pv1,pv2}.
  - If they are equal, joystick1/joystick2 take the new values in the same cycle frame_done is high.
  - If they differ, the outputs hold their values.
  - In both cases pv1/pv2 take the new frame.
REQ-016 Output update latency SHALL be one clk cycle from the slot-25 rise, and a stable input change SHALL reach the outputs at the end of the second complete frame that carries it.
REQ-017 A single-frame glitch (one frame differing from its neighbours) SHALL never appear on joystick1/joystick2.
REQ-018 A shadow bit not written during a frame SHALL retain its previous value; bits 0..11 are all written every frame, so no bit is unmapped.
REQ-019 The joy_data path SHALL contain no combinational logic to the outputs, and all outputs SHALL be registered.

Reset
REQ-020 While rst_n == 0 at a clk edge, the block SHALL set:
  - div_cnt = 0, slot = 0.
  - joy_clk = 0, joy_load = 0, frame_done = 0.
  - joystick1, joystick2, sh1, sh2, pv1, pv2 = 12'hFFF.
REQ-021 Reset asserted mid-frame SHALL abandon the partial frame with no commit and no frame_done pulse.
REQ-022 After release, the first rise SHALL occur HALF_DIV clk cycles later and SHALL be treated as slot 0.

Verification
REQ-023 Reset release, HALF_DIV=16, joy_data=1 constant:
  - joy_clk has a 32-clk period.
  - joy_load is low for 32 clk per 832-clk frame.
  - frame_done pulses every 832 clk.
  - Outputs stay 12'hFFF.
REQ-024 Model drives joy_data=0 only in slot 2 (sh1[8]) for every frame: joystick1 = 12'hEFF after the second frame_done, not the first.
REQ-025 Model drives joy_data=0 in slot 22 for one frame only: joystick1 stays 12'hFFF, and frame_done still pulses each frame.
REQ-026 Walking-zero sweep through slots 2..25, each held for 2 frames: exactly the mapped bit per REQ-014 clears in joystick1/joystick2 and all others stay 1.
REQ-027 rst_n pulsed low for 1 clk during slot 12:
  - Outputs return to 12'hFFF.
  - No frame_done occurs for that frame.
  - The next frame starts at slot 0 with the rise 16 clk after release.
REQ-028 HALF_DIV=2 build: rise occurs every 4 clk, and REQ-024 passes with frame length 104 clk.
